// File: rtl/in_flight_credit_tracker_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | in_flight_credit_tracker_pkg                                                |
// | Shared width helpers for the in-flight credit tracker.                      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package in_flight_credit_tracker_pkg;

    // Bits needed to index 'value' items; exact log2 for powers of two.
    function automatic int ift_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counter width able to hold max_depth exactly.
    function automatic int ift_count_width(input int max_depth);
        return ift_log2(max_depth) + 1;
    endfunction

    function automatic int ift_pool_entries(input int colors, input int min_depth,
                                            input int max_depth);
        return max_depth - colors * min_depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ift_color_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ift_color_counter                                                           |
// | Per-colour in-flight counter with quota comparison flags.                   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module ift_color_counter
    import in_flight_credit_tracker_pkg::*;
#(
    parameter int CW        = 10,
    parameter int MIN_DEPTH = 32
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          at_or_above_min,
    output logic          above_min,
    output logic          nonzero
);

    localparam logic [CW-1:0] c_min = CW'(MIN_DEPTH);
    localparam logic [CW-1:0] c_one = CW'(1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    // The parent only asserts inc/dec for accepted operations, so no clamping here.
    always_comb begin
        w_count_next = r_count;
        unique case ({inc, dec})
            2'b10:   w_count_next = r_count + c_one;
            2'b01:   w_count_next = r_count - c_one;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count           = r_count;
    assign count_next      = w_count_next;
    assign at_or_above_min = (r_count >= c_min);
    assign above_min       = (r_count > c_min);
    assign nonzero         = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/in_flight_credit_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | in_flight_credit_tracker                                                    |
// | Per-colour outstanding-request tracker with reserved quotas + shared pool.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module in_flight_credit_tracker
    import in_flight_credit_tracker_pkg::*;
#(
    parameter  int COLORS    = 4,
    parameter  int MIN_DEPTH = 32,
    parameter  int MAX_DEPTH = 512,
    localparam int CW        = ift_count_width(MAX_DEPTH),
    localparam int TW        = ift_log2(COLORS)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [TW-1:0]     push_tag,
    input  logic              pop,
    input  logic [TW-1:0]     pop_tag,
    input  logic              clr_err,
    output logic [COLORS-1:0] ready,
    output logic [CW-1:0]     total,
    output logic [CW-1:0]     pool_used,
    output logic              overflow,
    output logic              underflow
);

    localparam int            POOL_ENTRIES = ift_pool_entries(COLORS, MIN_DEPTH, MAX_DEPTH);
    localparam logic [CW-1:0] c_pool       = CW'(POOL_ENTRIES);
    localparam logic [CW-1:0] c_min        = CW'(MIN_DEPTH);

    logic [COLORS-1:0] r_ready;
    logic [CW-1:0]     r_total;
    logic [CW-1:0]     r_pool_used;
    logic              r_overflow;
    logic              r_underflow;

    logic [CW-1:0]     w_count      [COLORS];
    logic [CW-1:0]     w_count_next [COLORS];
    logic [COLORS-1:0] w_at_or_above_min;
    logic [COLORS-1:0] w_above_min;
    logic [COLORS-1:0] w_nonzero;
    logic [COLORS-1:0] w_ready_next;

    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_same_tag;
    logic              w_pool_inc;
    logic              w_pool_dec;
    logic [CW-1:0]     w_total_next;
    logic [CW-1:0]     w_pool_next;

    // Acceptance uses the registered ready so issuers see exactly what they tested.
    assign w_push_ok  = push && r_ready[push_tag];
    assign w_pop_ok   = pop && w_nonzero[pop_tag];
    assign w_same_tag = w_push_ok && w_pop_ok && (push_tag == pop_tag);

    // A same-tag push/pop leaves the count unchanged, so it must not move the pool either.
    assign w_pool_inc = w_push_ok && w_at_or_above_min[push_tag] && !w_same_tag;
    assign w_pool_dec = w_pop_ok && w_above_min[pop_tag] && !w_same_tag;

    assign w_total_next = r_total + {{(CW-1){1'b0}}, w_push_ok} - {{(CW-1){1'b0}}, w_pop_ok};
    assign w_pool_next  = r_pool_used + {{(CW-1){1'b0}}, w_pool_inc}
                                      - {{(CW-1){1'b0}}, w_pool_dec};

    for (genvar c = 0; c < COLORS; c++) begin : g_color
        ift_color_counter #(
            .CW        (CW),
            .MIN_DEPTH (MIN_DEPTH)
        ) u_counter (
            .clk             (clk),
            .rst_n           (rst_n),
            .inc             (w_push_ok && (push_tag == TW'(c))),
            .dec             (w_pop_ok && (pop_tag == TW'(c))),
            .count           (w_count[c]),
            .count_next      (w_count_next[c]),
            .at_or_above_min (w_at_or_above_min[c]),
            .above_min       (w_above_min[c]),
            .nonzero         (w_nonzero[c])
        );
    end

    if (POOL_ENTRIES > 0) begin : g_pool
        always_comb begin
            w_ready_next = '0;
            for (int c = 0; c < COLORS; c++) begin
                w_ready_next[c] = (w_count_next[c] < c_min) || (w_pool_next < c_pool);
            end
        end
    end else begin : g_no_pool
        always_comb begin
            w_ready_next = '0;
            for (int c = 0; c < COLORS; c++) begin
                w_ready_next[c] = (w_count_next[c] < c_min);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= '1;
            r_total     <= '0;
            r_pool_used <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_ready     <= w_ready_next;
            r_total     <= w_total_next;
            r_pool_used <= w_pool_next;
            // A new error in the same cycle as clr_err keeps the flag set.
            if (push && !r_ready[push_tag]) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (pop && !w_nonzero[pop_tag]) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign ready     = r_ready;
    assign total     = r_total;
    assign pool_used = r_pool_used;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifndef SYNTHESIS
    logic [CW-1:0] w_sum_count;
    logic [CW-1:0] w_sum_excess;

    always_comb begin
        w_sum_count  = '0;
        w_sum_excess = '0;
        for (int c = 0; c < COLORS; c++) begin
            w_sum_count = w_sum_count + w_count[c];
            if (w_count[c] > c_min) begin
                w_sum_excess = w_sum_excess + (w_count[c] - c_min);
            end
        end
    end

    a_total_is_sum: assert property (@(posedge clk) disable iff (!rst_n)
        r_total == w_sum_count);
    a_pool_is_excess: assert property (@(posedge clk) disable iff (!rst_n)
        r_pool_used == w_sum_excess);
    a_total_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_total <= CW'(MAX_DEPTH));

    if (POOL_ENTRIES > 0) begin : g_pool_chk
        a_pool_bound: assert property (@(posedge clk) disable iff (!rst_n)
            r_pool_used <= c_pool);
    end else begin : g_no_pool_chk
        a_pool_empty: assert property (@(posedge clk) disable iff (!rst_n)
            r_pool_used == '0);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_in_flight_credit_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_in_flight_credit_tracker                                                 |
// | Three configurations checked cycle-by-cycle against a behavioural model.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_in_flight_credit_tracker;

    logic clk;
    logic rst_n;

    // Instance 0: 4/32/512 (pool 384), 1: 8/16/256 (pool 128), 2: 4/32/128 (pool 0)
    int cfg_col [3] = '{4, 8, 4};
    int cfg_min [3] = '{32, 16, 32};
    int cfg_max [3] = '{512, 256, 128};

    logic       a_push, a_pop, a_clr;
    logic [1:0] a_ptag, a_qtag;
    logic [3:0] a_ready;
    logic [9:0] a_total, a_pool;
    logic       a_ovf, a_udf;

    logic       b_push, b_pop, b_clr;
    logic [2:0] b_ptag, b_qtag;
    logic [7:0] b_ready;
    logic [8:0] b_total, b_pool;
    logic       b_ovf, b_udf;

    logic       c_push, c_pop, c_clr;
    logic [1:0] c_ptag, c_qtag;
    logic [3:0] c_ready;
    logic [7:0] c_total, c_pool;
    logic       c_ovf, c_udf;

    in_flight_credit_tracker #(.COLORS(4), .MIN_DEPTH(32), .MAX_DEPTH(512)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .push(a_push), .push_tag(a_ptag), .pop(a_pop),
        .pop_tag(a_qtag), .clr_err(a_clr), .ready(a_ready), .total(a_total),
        .pool_used(a_pool), .overflow(a_ovf), .underflow(a_udf));

    in_flight_credit_tracker #(.COLORS(8), .MIN_DEPTH(16), .MAX_DEPTH(256)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .push(b_push), .push_tag(b_ptag), .pop(b_pop),
        .pop_tag(b_qtag), .clr_err(b_clr), .ready(b_ready), .total(b_total),
        .pool_used(b_pool), .overflow(b_ovf), .underflow(b_udf));

    in_flight_credit_tracker #(.COLORS(4), .MIN_DEPTH(32), .MAX_DEPTH(128)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .push(c_push), .push_tag(c_ptag), .pop(c_pop),
        .pop_tag(c_qtag), .clr_err(c_clr), .ready(c_ready), .total(c_total),
        .pool_used(c_pool), .overflow(c_ovf), .underflow(c_udf));

    int n_total;
    int n_bad;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt [3][8];
    int m_ovf [3];
    int m_udf [3];

    function automatic int m_total(input int k);
        int s = 0;
        for (int c = 0; c < 8; c++) s += m_cnt[k][c];
        return s;
    endfunction

    function automatic int m_pool(input int k);
        int s = 0;
        for (int c = 0; c < 8; c++)
            if (m_cnt[k][c] > cfg_min[k]) s += m_cnt[k][c] - cfg_min[k];
        return s;
    endfunction

    function automatic int m_ready(input int k);
        int r = 0;
        int pool_cap = cfg_max[k] - cfg_col[k] * cfg_min[k];
        for (int c = 0; c < cfg_col[k]; c++)
            if (m_cnt[k][c] < cfg_min[k] || m_pool(k) < pool_cap) r |= (1 << c);
        return r;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 8; c++) m_cnt[k][c] = 0;
            m_ovf[k] = 0;
            m_udf[k] = 0;
        end
    endtask

    task automatic m_step(input int k, input bit push, input int ptag, input bit pop,
                          input int qtag, input bit clr);
        int  rdy = m_ready(k);
        bit  push_ok = push && rdy[ptag];
        bit  pop_ok  = pop && (m_cnt[k][qtag] > 0);
        if (push_ok) m_cnt[k][ptag]++;
        if (pop_ok)  m_cnt[k][qtag]--;
        if (push && !push_ok) m_ovf[k] = 1;
        else if (clr)         m_ovf[k] = 0;
        if (pop && !pop_ok)   m_udf[k] = 1;
        else if (clr)         m_udf[k] = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            m_step(0, a_push, int'(a_ptag), a_pop, int'(a_qtag), a_clr);
            m_step(1, b_push, int'(b_ptag), b_pop, int'(b_qtag), b_clr);
            m_step(2, c_push, int'(c_ptag), c_pop, int'(c_qtag), c_clr);
        end
    end

    task automatic cmp_inst(input int k, input int rdy, input int tot, input int pl,
                            input int ov, input int ud);
        chk($sformatf("inst%0d_ready", k), rdy, m_ready(k));
        chk($sformatf("inst%0d_total", k), tot, m_total(k));
        chk($sformatf("inst%0d_pool_used", k), pl, m_pool(k));
        chk($sformatf("inst%0d_overflow", k), ov, m_ovf[k]);
        chk($sformatf("inst%0d_underflow", k), ud, m_udf[k]);
    endtask

    always @(negedge clk) begin
        cmp_inst(0, int'(a_ready), int'(a_total), int'(a_pool), int'(a_ovf), int'(a_udf));
        cmp_inst(1, int'(b_ready), int'(b_total), int'(b_pool), int'(b_ovf), int'(b_udf));
        cmp_inst(2, int'(c_ready), int'(c_total), int'(c_pool), int'(c_ovf), int'(c_udf));
    end

    // ---------------- stimulus ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input bit push, input int ptag, input bit pop, input int qtag,
                         input bit clr);
        a_push = push; a_ptag = 2'(ptag); a_pop = pop; a_qtag = 2'(qtag); a_clr = clr;
    endtask

    task automatic rand_ops(input int k, input int pbias, output bit push, output int ptag,
                            output bit pop, output int qtag, output bit clr);
        int rdy = m_ready(k);
        ptag = $urandom_range(0, cfg_col[k] - 1);
        qtag = $urandom_range(0, cfg_col[k] - 1);
        push = ($urandom_range(0, 99) < pbias) && rdy[ptag];
        pop  = ($urandom_range(0, 99) < (100 - pbias));
        clr  = ($urandom_range(0, 99) < 2);
    endtask

    task automatic check_a(input string tag, input int rdy, input int tot, input int pl,
                           input int ov, input int ud);
        chk({tag, "_ready"}, int'(a_ready), rdy);
        chk({tag, "_total"}, int'(a_total), tot);
        chk({tag, "_pool_used"}, int'(a_pool), pl);
        chk({tag, "_overflow"}, int'(a_ovf), ov);
        chk({tag, "_underflow"}, int'(a_udf), ud);
    endtask

    initial begin
        bit p, q, cl;
        int pt, qt;
        n_total = 0;
        n_bad   = 0;
        a_set(0, 0, 0, 0, 0);
        b_push = 0; b_ptag = 0; b_pop = 0; b_qtag = 0; b_clr = 0;
        c_push = 0; c_ptag = 0; c_pop = 0; c_qtag = 0; c_clr = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_a("reset", 4'b1111, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();

        // Fill colour 0 through its quota and the whole pool.
        a_set(1, 0, 0, 0, 0);
        repeat (416) step();
        check_a("fill0", 4'b1110, 416, 384, 0, 0);
        a_set(1, 1, 0, 0, 0);
        repeat (32) step();
        check_a("fill1", 4'b1100, 448, 384, 0, 0);
        chk("model_total_fill", m_total(0), 448);
        chk("model_ready_fill", m_ready(0), 4'b1100);

        // Push to a not-ready colour is dropped.
        a_set(1, 0, 0, 0, 0);
        step();
        check_a("ovf_push", 4'b1100, 448, 384, 1, 0);
        a_set(0, 0, 1, 0, 0);
        step();
        check_a("pop0", 4'b1111, 447, 383, 1, 0);
        a_set(0, 0, 0, 0, 1);
        step();
        check_a("clr_ovf", 4'b1111, 447, 383, 0, 0);

        // Drain colour 0 down to exactly its quota.
        a_set(0, 0, 1, 0, 0);
        repeat (383) step();
        check_a("drain0", 4'b1111, 64, 0, 0, 0);
        chk("model_pool_drain", m_pool(0), 0);
        a_set(1, 0, 1, 0, 0);
        step();
        check_a("same_tag_at_min", 4'b1111, 64, 0, 0, 0);
        a_set(1, 1, 1, 0, 0);
        step();
        check_a("diff_tag", 4'b1111, 64, 1, 0, 0);

        // Underflow on an empty colour, clear, and set-wins-over-clear.
        a_set(0, 0, 1, 3, 0);
        step();
        check_a("udf_pop", 4'b1111, 64, 1, 0, 1);
        a_set(0, 0, 0, 0, 1);
        step();
        check_a("clr_udf", 4'b1111, 64, 1, 0, 0);
        a_set(0, 0, 1, 3, 1);
        step();
        check_a("clr_and_udf", 4'b1111, 64, 1, 0, 1);

        // Asynchronous reset in the middle of traffic.
        a_set(1, 2, 0, 0, 0);
        repeat (5) step();
        chk("pre_reset_total", int'(a_total), 69);
        #1 rst_n = 1'b0;
        #1 check_a("async_reset", 4'b1111, 0, 0, 0, 0);
        @(negedge clk);
        a_set(0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        step();

        // Randomized traffic honouring ready, alternating fill and drain phases.
        for (int cyc = 0; cyc < 18000; cyc++) begin
            int bias = ((cyc / 1500) % 2 == 0) ? 80 : 25;
            rand_ops(0, bias, p, pt, q, qt, cl);
            a_set(p, pt, q, qt, cl);
            rand_ops(1, bias, p, pt, q, qt, cl);
            b_push = p; b_ptag = 3'(pt); b_pop = q; b_qtag = 3'(qt); b_clr = cl;
            rand_ops(2, bias, p, pt, q, qt, cl);
            c_push = p; c_ptag = 2'(pt); c_pop = q; c_qtag = 2'(qt); c_clr = cl;
            step();
        end
        a_set(0, 0, 0, 0, 0);
        b_push = 0; b_pop = 0; c_push = 0; c_pop = 0;
        step();
        chk("rand_no_ovf_a", int'(a_ovf), 0);
        chk("rand_no_ovf_b", int'(b_ovf), 0);
        chk("rand_no_ovf_c", int'(c_ovf), 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
